ice_cream_dispenser: RTL

Downstream consumer of the ice-cream vending FSM. Takes the ball count from the vending controller, drives the scoop mechanism one ball at a time via a req/done handshake, and reports completion, totals and faults. Sits between the vending FSM output and the physical scoop actuator.

---
 rtl/ice_cream_dispenser_if.sv | 28 ++
 rtl/ice_cream_dispenser.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ice_cream_dispenser_if.sv
// Signal bundle between the vending controller / scoop actuator side (master)
// and the ice-cream dispenser (slave).
interface ice_cream_dispenser_if #(
    parameter int CNT_W = 8
);
    logic             order;
    logic [1:0]       ice_cream_balls;
    logic             scoop_done;
    logic             fault_clr;
    logic             ready;
    logic             scoop_req;
    logic             served;
    logic             fault;
    logic             order_drop;
    logic [1:0]       remaining;
    logic [CNT_W-1:0] total_served;
    logic [2:0]       state;

    modport master (
        output order, ice_cream_balls, scoop_done, fault_clr,
        input  ready, scoop_req, served, fault, order_drop, remaining, total_served, state
    );

    modport slave (
        input  order, ice_cream_balls, scoop_done, fault_clr,
        output ready, scoop_req, served, fault, order_drop, remaining, total_served, state
    );
endinterface

// File: rtl/ice_cream_dispenser.sv
// Scoop sequencer: one ball per req/done handshake, with timeout fault and totals.
// Define DISPENSER_QUEUE_EN to add a one-entry buffer for orders arriving while busy.
module ice_cream_dispenser #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input logic                  clk,
    input logic                  reset,
    ice_cream_dispenser_if.slave bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SCOOP = 3'b001,
        GAP   = 3'b010,
        DONE  = 3'b011,
        FAULT = 3'b100
    } state_t;

    state_t           state_q, state_d;
    logic             order_prev_q;
    logic [1:0]       remaining_q, remaining_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic             drop_q, drop_d;
    logic             ord_edge;
    logic             tmo_hit;
`ifdef DISPENSER_QUEUE_EN
    logic             buf_valid_q, buf_valid_d;
    logic [1:0]       buf_cnt_q, buf_cnt_d;
`endif

    assign ord_edge = bus.order & ~order_prev_q;
    assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        tmo_d       = tmo_q;
        total_d     = total_q;
        drop_d      = 1'b0;
`ifdef DISPENSER_QUEUE_EN
        buf_valid_d = buf_valid_q;
        buf_cnt_d   = buf_cnt_q;
        if (ord_edge && state_q != IDLE) begin
            if (bus.ice_cream_balls != 2'd0 && !buf_valid_q && state_q != FAULT) begin
                buf_valid_d = 1'b1;
                buf_cnt_d   = bus.ice_cream_balls;
            end else begin
                drop_d = 1'b1;
            end
        end
`else
        if (ord_edge && state_q != IDLE) drop_d = 1'b1;
`endif

        case (state_q)
            IDLE: begin
                if (ord_edge && bus.ice_cream_balls != 2'd0) begin
                    state_d     = SCOOP;
                    remaining_d = bus.ice_cream_balls;
                    tmo_d       = '0;
                end
            end
            SCOOP: begin
                // A delivery in the timeout cycle still counts; done has priority.
                if (bus.scoop_done) begin
                    remaining_d = remaining_q - 2'd1;
                    total_d     = total_q + CNT_W'(1);
                    state_d     = (remaining_q == 2'd1) ? DONE : GAP;
                end else if (tmo_hit) begin
                    state_d = FAULT;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            GAP: begin
                state_d = SCOOP;
                tmo_d   = '0;
            end
            DONE: begin
                state_d = IDLE;
`ifdef DISPENSER_QUEUE_EN
                // Either the held order or one accepted this very cycle starts at once.
                if (buf_valid_d) begin
                    state_d     = SCOOP;
                    remaining_d = buf_cnt_d;
                    tmo_d       = '0;
                    buf_valid_d = 1'b0;
                end
`endif
            end
            FAULT: begin
`ifdef DISPENSER_QUEUE_EN
                buf_valid_d = 1'b0;
`endif
                if (bus.fault_clr) begin
                    state_d     = IDLE;
                    remaining_d = 2'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            order_prev_q <= 1'b0;
            remaining_q  <= 2'd0;
            tmo_q        <= '0;
            total_q      <= '0;
            drop_q       <= 1'b0;
`ifdef DISPENSER_QUEUE_EN
            buf_valid_q  <= 1'b0;
            buf_cnt_q    <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            order_prev_q <= bus.order;
            remaining_q  <= remaining_d;
            tmo_q        <= tmo_d;
            total_q      <= total_d;
            drop_q       <= drop_d;
`ifdef DISPENSER_QUEUE_EN
            buf_valid_q  <= buf_valid_d;
            buf_cnt_q    <= buf_cnt_d;
`endif
        end
    end

    assign bus.ready        = (state_q == IDLE);
    assign bus.scoop_req    = (state_q == SCOOP);
    assign bus.served       = (state_q == DONE);
    assign bus.fault        = (state_q == FAULT);
    assign bus.order_drop   = drop_q;
    assign bus.remaining    = remaining_q;
    assign bus.total_served = total_q;
    assign bus.state        = state_q;
endmodule
